cmd_arbiter: RTL and testbench

CMD_ARBITER -- requirements
Module: cmd_arbiter

---
 rtl/cmd_arbiter.sv | 218 +++++++++++++++++++++
 tb/tb_cmd_arbiter.sv | 430 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cmd_arbiter.sv
// cmd_arbiter: round-robin arbiter granting three requesters access to one
// shared command sender, with a transaction timeout and a post-transaction
// guard interval.
//
// Ports
//   clk            sole clock, rising edge
//   rst            synchronous active-high reset
//   req[2:0]       per-requester level request, held until ack or err
//   cmd0..cmd2     command offered by each requester (CMD_W bits)
//   ready_command  sender status: 1 = idle, 0 = executing
//   command        latched command of the current/last owner
//   start          issue strobe to the sender
//   grant_id       index of the current/last owner
//   busy           transaction or guard interval in progress
//   ack[2:0]       one-cycle completion pulse to the owner
//   err[2:0]       one-cycle timeout pulse to the owner
module cmd_arbiter #(
  parameter int unsigned CMD_W          = 3,
  parameter int unsigned GAP_CYCLES     = 100000000,
  parameter int unsigned TIMEOUT_CYCLES = 50000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       req,
  input  logic [CMD_W-1:0] cmd0,
  input  logic [CMD_W-1:0] cmd1,
  input  logic [CMD_W-1:0] cmd2,
  input  logic             ready_command,
  output logic [CMD_W-1:0] command,
  output logic             start,
  output logic [1:0]       grant_id,
  output logic             busy,
  output logic [2:0]       ack,
  output logic [2:0]       err
);

  localparam int unsigned CNT_W = 28;

  // Terminal counts; both counters compare against N-1 so that a count of
  // N cycles ends on the Nth cycle.
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 1);

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_ISSUE     = 2'd1;
  localparam logic [1:0] ST_WAIT_DONE = 2'd2;
  localparam logic [1:0] ST_GAP       = 2'd3;

  logic [1:0]       state_q,      state_d;
  logic [CMD_W-1:0] command_q,    command_d;
  logic             start_q,      start_d;
  logic [1:0]       grant_id_q,   grant_id_d;
  logic             busy_q,       busy_d;
  logic [2:0]       ack_q,        ack_d;
  logic [2:0]       err_q,        err_d;
  logic [1:0]       last_grant_q, last_grant_d;
  logic [CNT_W-1:0] tmo_cnt_q,    tmo_cnt_d;
  logic [CNT_W-1:0] gap_cnt_q,    gap_cnt_d;

  // Round-robin winner selection
  logic [1:0]       ord0, ord1, ord2;
  logic             win_valid;
  logic [1:0]       win_idx;
  logic [CMD_W-1:0] win_cmd;

  // Search order starts one past the last owner and wraps modulo 3.
  always_comb begin
    ord0 = 2'd0;
    ord1 = 2'd1;
    ord2 = 2'd2;
    unique case (last_grant_q)
      2'd0: begin
        ord0 = 2'd1;
        ord1 = 2'd2;
        ord2 = 2'd0;
      end
      2'd1: begin
        ord0 = 2'd2;
        ord1 = 2'd0;
        ord2 = 2'd1;
      end
      default: begin
        ord0 = 2'd0;
        ord1 = 2'd1;
        ord2 = 2'd2;
      end
    endcase
  end

  // Pick the first requester in search order.
  always_comb begin
    win_valid = |req;
    win_idx   = ord2;
    if (req[ord0]) begin
      win_idx = ord0;
    end else if (req[ord1]) begin
      win_idx = ord1;
    end else begin
      win_idx = ord2;
    end
  end

  // Command of the selected requester
  always_comb begin
    win_cmd = cmd2;
    unique case (win_idx)
      2'd0:    win_cmd = cmd0;
      2'd1:    win_cmd = cmd1;
      default: win_cmd = cmd2;
    endcase
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d      = state_q;
    command_d    = command_q;
    start_d      = start_q;
    grant_id_d   = grant_id_q;
    busy_d       = busy_q;
    ack_d        = 3'b000;
    err_d        = 3'b000;
    last_grant_d = last_grant_q;
    tmo_cnt_d    = tmo_cnt_q;
    gap_cnt_d    = gap_cnt_q;

    unique case (state_q)
      ST_IDLE: begin
        // A busy sender blocks any grant.
        if (win_valid && ready_command) begin
          command_d    = win_cmd;
          grant_id_d   = win_idx;
          last_grant_d = win_idx;
          start_d      = 1'b1;
          busy_d       = 1'b1;
          tmo_cnt_d    = '0;
          state_d      = ST_ISSUE;
        end
      end

      ST_ISSUE: begin
        // Timeout is checked first: the sender only accepting the command
        // is not a completion.
        if (tmo_cnt_q == TMO_LAST) begin
          err_d     = 3'b001 << grant_id_q;
          start_d   = 1'b0;
          gap_cnt_d = '0;
          state_d   = ST_GAP;
        end else if (!ready_command) begin
          start_d   = 1'b0;
          tmo_cnt_d = tmo_cnt_q + CNT_W'(1);
          state_d   = ST_WAIT_DONE;
        end else begin
          tmo_cnt_d = tmo_cnt_q + CNT_W'(1);
        end
      end

      ST_WAIT_DONE: begin
        // Completion has priority over a coincident timeout.
        if (ready_command) begin
          ack_d     = 3'b001 << grant_id_q;
          gap_cnt_d = '0;
          state_d   = ST_GAP;
        end else if (tmo_cnt_q == TMO_LAST) begin
          err_d     = 3'b001 << grant_id_q;
          gap_cnt_d = '0;
          state_d   = ST_GAP;
        end else begin
          tmo_cnt_d = tmo_cnt_q + CNT_W'(1);
        end
      end

      default: begin
        // Guard interval: stays exactly GAP_CYCLES cycles.
        if (gap_cnt_q == GAP_LAST) begin
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + CNT_W'(1);
        end
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      command_q    <= '0;
      start_q      <= 1'b0;
      grant_id_q   <= 2'd0;
      busy_q       <= 1'b0;
      ack_q        <= 3'b000;
      err_q        <= 3'b000;
      last_grant_q <= 2'd2;
      tmo_cnt_q    <= '0;
      gap_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      command_q    <= command_d;
      start_q      <= start_d;
      grant_id_q   <= grant_id_d;
      busy_q       <= busy_d;
      ack_q        <= ack_d;
      err_q        <= err_d;
      last_grant_q <= last_grant_d;
      tmo_cnt_q    <= tmo_cnt_d;
      gap_cnt_q    <= gap_cnt_d;
    end
  end

  assign command  = command_q;
  assign start    = start_q;
  assign grant_id = grant_id_q;
  assign busy     = busy_q;
  assign ack      = ack_q;
  assign err      = err_q;

endmodule

// File: tb/tb_cmd_arbiter.sv
// Testbench for cmd_arbiter with GAP_CYCLES=4, TIMEOUT_CYCLES=16, CMD_W=3.
// Expected grants and completions are queued as stimulus is driven; a
// negedge monitor pops and compares them when start rises or ack/err pulse.
module tb_cmd_arbiter;

  localparam int unsigned CMD_W = 3;
  localparam int unsigned GAP   = 4;
  localparam int unsigned TMO   = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic [2:0]       req;
  logic [CMD_W-1:0] cmd0, cmd1, cmd2;
  logic             ready_command;
  logic [CMD_W-1:0] command;
  logic             start;
  logic [1:0]       grant_id;
  logic             busy;
  logic [2:0]       ack;
  logic [2:0]       err;

  cmd_arbiter #(
    .CMD_W          (CMD_W),
    .GAP_CYCLES     (GAP),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .req           (req),
    .cmd0          (cmd0),
    .cmd1          (cmd1),
    .cmd2          (cmd2),
    .ready_command (ready_command),
    .command       (command),
    .start         (start),
    .grant_id      (grant_id),
    .busy          (busy),
    .ack           (ack),
    .err           (err)
  );

  always #5 clk = ~clk;

  int tests_run    = 0;
  int tests_failed = 0;
  int cyc          = 0;

  typedef struct packed {
    logic [1:0]       id;
    logic [CMD_W-1:0] cmd;
  } grant_t;

  typedef struct packed {
    logic [2:0] ack;
    logic [2:0] err;
  } done_t;

  grant_t exp_grant_q[$];
  done_t  exp_done_q[$];
  grant_t mon_g;
  done_t  mon_d;
  logic   start_prev = 1'b0;

  always @(posedge clk) cyc++;

  // Scoreboard monitor: grants on start rise, completions on ack/err pulses.
  always @(negedge clk) begin
    if (rst) begin
      start_prev = 1'b0;
    end else begin
      if (start && !start_prev) begin
        tests_run++;
        if (exp_grant_q.size() == 0) begin
          tests_failed++;
          $display("FAIL grant_unexpected: id=%0d cmd=%0d, none expected", grant_id, command);
        end else begin
          mon_g = exp_grant_q.pop_front();
          if (grant_id !== mon_g.id || command !== mon_g.cmd) begin
            tests_failed++;
            $display("FAIL grant: id=%0d cmd=%0d, want id=%0d cmd=%0d",
                     grant_id, command, mon_g.id, mon_g.cmd);
          end
        end
      end
      if (ack !== 3'b000 || err !== 3'b000) begin
        tests_run++;
        if (exp_done_q.size() == 0) begin
          tests_failed++;
          $display("FAIL done_unexpected: ack=%b err=%b, none expected", ack, err);
        end else begin
          mon_d = exp_done_q.pop_front();
          if (ack !== mon_d.ack || err !== mon_d.err) begin
            tests_failed++;
            $display("FAIL done: ack=%b err=%b, want ack=%b err=%b",
                     ack, err, mon_d.ack, mon_d.err);
          end
        end
      end
      start_prev = start;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
  endtask

  // Waits (bounded) for start; returns just after the grant edge.
  task automatic wait_start(input string name, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      tick(1);
      if (start === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      tests_run++;
      tests_failed++;
      $display("FAIL %s_wait_start: start never rose within 60 cycles", name);
    end
  endtask

  task automatic wait_idle(input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (busy === 1'b0) begin
        ok = 1'b1;
        break;
      end
      tick(1);
    end
    if (!ok) begin
      tests_run++;
      tests_failed++;
      $display("FAIL %s_wait_idle: busy stuck high", name);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req = 3'b000;
    cmd0 = '0; cmd1 = '0; cmd2 = '0;
    ready_command = 1'b1;
    tick(2);
    tests_run++;
    if (command !== 3'd0 || start !== 1'b0 || grant_id !== 2'd0) begin
      tests_failed++;
      $display("FAIL reset_cmd_start_gid: cmd=%0d start=%b gid=%0d, want 0 0 0", command, start, grant_id);
    end
    tests_run++;
    if (busy !== 1'b0 || ack !== 3'b000 || err !== 3'b000) begin
      tests_failed++;
      $display("FAIL reset_busy_ack_err: busy=%b ack=%b err=%b, want 0 000 000", busy, ack, err);
    end
    rst = 1'b0;
    tick(1);
  endtask

  // One transaction; requester drops req and changes cmd mid-flight.
  task automatic test_single();
    bit ok;
    req = 3'b001; cmd0 = 3'd5; ready_command = 1'b1;
    exp_grant_q.push_back('{id: 2'd0, cmd: 3'd5});
    wait_start("single", ok);
    if (!ok) return;
    tests_run++;
    if (busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL single_busy_at_grant: busy=%b, want 1", busy);
    end
    tick(1);
    tests_run++;
    if (start !== 1'b1) begin
      tests_failed++;
      $display("FAIL single_start_cycle2: start=%b, want 1", start);
    end
    ready_command = 1'b0;
    cmd0 = 3'd2;
    req = 3'b000;
    tick(1);
    tests_run++;
    if (start !== 1'b0 || command !== 3'd5) begin
      tests_failed++;
      $display("FAIL single_start_drop: start=%b cmd=%0d, want 0 5", start, command);
    end
    tick(2);
    exp_done_q.push_back('{ack: 3'b001, err: 3'b000});
    ready_command = 1'b1;
    tick(1);
    tests_run++;
    if (ack !== 3'b001) begin
      tests_failed++;
      $display("FAIL single_ack: ack=%b, want 001", ack);
    end
    tick(1);
    tests_run++;
    if (ack !== 3'b000) begin
      tests_failed++;
      $display("FAIL single_ack_width: ack=%b, want 000", ack);
    end
    tick(2);
    tests_run++;
    if (busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL single_gap_busy: busy=%b, want 1", busy);
    end
    tick(1);
    tests_run++;
    if (busy !== 1'b0 || command !== 3'd5 || grant_id !== 2'd0) begin
      tests_failed++;
      $display("FAIL single_gap_end: busy=%b cmd=%0d gid=%0d, want 0 5 0", busy, command, grant_id);
    end
  endtask

  // All three request with a fastest-possible sender: spacing is exactly 3+GAP.
  task automatic test_contention();
    bit ok;
    int last_rise;
    do_reset();
    req = 3'b111; cmd0 = 3'd1; cmd1 = 3'd2; cmd2 = 3'd3; ready_command = 1'b1;
    for (int k = 0; k < 3; k++) exp_grant_q.push_back('{id: 2'(k), cmd: 3'(k + 1)});
    last_rise = 0;
    for (int k = 0; k < 3; k++) begin
      wait_start("contention", ok);
      if (!ok) return;
      tests_run++;
      if (grant_id !== 2'(k)) begin
        tests_failed++;
        $display("FAIL contention_order: gid=%0d, want %0d", grant_id, k);
      end
      if (k > 0) begin
        tests_run++;
        if (cyc - last_rise != 3 + int'(GAP)) begin
          tests_failed++;
          $display("FAIL contention_spacing: %0d cycles, want %0d", cyc - last_rise, 3 + GAP);
        end
      end
      last_rise = cyc;
      ready_command = 1'b0;
      tick(1);
      ready_command = 1'b1;
      exp_done_q.push_back('{ack: 3'(1 << k), err: 3'b000});
      tick(1);
      tests_run++;
      if (ack !== 3'(1 << k)) begin
        tests_failed++;
        $display("FAIL contention_ack: ack=%b, want %b", ack, 3'(1 << k));
      end
      req[k] = 1'b0;
    end
  endtask

  // Sender never accepts: start held for TMO cycles then err.
  task automatic test_timeout();
    bit ok;
    int n;
    req = 3'b010; cmd1 = 3'd6; ready_command = 1'b1;
    exp_grant_q.push_back('{id: 2'd1, cmd: 3'd6});
    exp_done_q.push_back('{ack: 3'b000, err: 3'b010});
    wait_start("timeout", ok);
    if (!ok) return;
    n = 1;
    for (int i = 0; i < 40; i++) begin
      tick(1);
      if (start === 1'b1) n++;
      else break;
    end
    tests_run++;
    if (n != int'(TMO)) begin
      tests_failed++;
      $display("FAIL timeout_start_len: %0d cycles, want %0d", n, TMO);
    end
    tests_run++;
    if (err !== 3'b010 || ack !== 3'b000) begin
      tests_failed++;
      $display("FAIL timeout_err: err=%b ack=%b, want 010 000", err, ack);
    end
    req = 3'b000;
    tick(3);
    tests_run++;
    if (busy !== 1'b1 || err !== 3'b000) begin
      tests_failed++;
      $display("FAIL timeout_gap: busy=%b err=%b, want 1 000", busy, err);
    end
    tick(1);
    tests_run++;
    if (busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL timeout_gap_end: busy=%b, want 0", busy);
    end
  endtask

  // Completion on the timeout cycle wins; one cycle later the timeout fires.
  task automatic test_simultaneous();
    bit ok;
    req = 3'b001; cmd0 = 3'd4; ready_command = 1'b1;
    exp_grant_q.push_back('{id: 2'd0, cmd: 3'd4});
    exp_done_q.push_back('{ack: 3'b001, err: 3'b000});
    wait_start("simul", ok);
    if (!ok) return;
    ready_command = 1'b0;
    tick(int'(TMO) - 1);
    ready_command = 1'b1;
    tick(1);
    tests_run++;
    if (ack !== 3'b001 || err !== 3'b000) begin
      tests_failed++;
      $display("FAIL simul_ack_wins: ack=%b err=%b, want 001 000", ack, err);
    end
    req = 3'b000;

    req = 3'b001;
    exp_grant_q.push_back('{id: 2'd0, cmd: 3'd4});
    exp_done_q.push_back('{ack: 3'b000, err: 3'b001});
    wait_start("late", ok);
    if (!ok) return;
    ready_command = 1'b0;
    tick(int'(TMO));
    tests_run++;
    if (err !== 3'b001 || ack !== 3'b000) begin
      tests_failed++;
      $display("FAIL late_wait_timeout: err=%b ack=%b, want 001 000", err, ack);
    end
    ready_command = 1'b1;
    req = 3'b000;
  endtask

  // Busy sender blocks the grant; grant follows the edge after ready returns.
  task automatic test_sender_busy();
    wait_idle("sender_busy");
    ready_command = 1'b0;
    req = 3'b100; cmd2 = 3'd7;
    for (int i = 0; i < 5; i++) begin
      tick(1);
      tests_run++;
      if (start !== 1'b0 || busy !== 1'b0) begin
        tests_failed++;
        $display("FAIL sender_busy_hold: start=%b busy=%b, want 0 0", start, busy);
      end
    end
    ready_command = 1'b1;
    exp_grant_q.push_back('{id: 2'd2, cmd: 3'd7});
    tick(1);
    tests_run++;
    if (start !== 1'b1 || grant_id !== 2'd2) begin
      tests_failed++;
      $display("FAIL sender_busy_grant: start=%b gid=%0d, want 1 2", start, grant_id);
    end
    ready_command = 1'b0;
    tick(1);
    ready_command = 1'b1;
    exp_done_q.push_back('{ack: 3'b100, err: 3'b000});
    tick(1);
    req = 3'b000;
  endtask

  // Reset during WAIT_DONE aborts silently and restores requester-0 priority.
  task automatic test_reset_mid();
    bit ok;
    wait_idle("reset_mid");
    req = 3'b001; cmd0 = 3'd3; ready_command = 1'b1;
    exp_grant_q.push_back('{id: 2'd0, cmd: 3'd3});
    wait_start("reset_mid", ok);
    if (!ok) return;
    ready_command = 1'b0;
    tick(2);
    rst = 1'b1;
    tick(1);
    tests_run++;
    if (command !== 3'd0 || start !== 1'b0 || grant_id !== 2'd0 ||
        busy !== 1'b0 || ack !== 3'b000 || err !== 3'b000) begin
      tests_failed++;
      $display("FAIL reset_mid_outputs: cmd=%0d start=%b gid=%0d busy=%b ack=%b err=%b, want all 0",
               command, start, grant_id, busy, ack, err);
    end
    rst = 1'b0;
    ready_command = 1'b1;
    req = 3'b000;
    tick(3);
    tests_run++;
    if (ack !== 3'b000 || err !== 3'b000) begin
      tests_failed++;
      $display("FAIL reset_mid_no_ack: ack=%b err=%b, want 000 000", ack, err);
    end
    req = 3'b111; cmd0 = 3'd6; cmd1 = 3'd1; cmd2 = 3'd2;
    exp_grant_q.push_back('{id: 2'd0, cmd: 3'd6});
    wait_start("reset_mid_regrant", ok);
    if (!ok) return;
    tests_run++;
    if (grant_id !== 2'd0) begin
      tests_failed++;
      $display("FAIL reset_mid_first_prio: gid=%0d, want 0", grant_id);
    end
    ready_command = 1'b0;
    tick(1);
    ready_command = 1'b1;
    exp_done_q.push_back('{ack: 3'b001, err: 3'b000});
    tick(1);
    req = 3'b000;
    tick(int'(GAP) + 2);
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_timeout();
    test_simultaneous();
    test_sender_busy();
    test_reset_mid();
    tests_run++;
    if (exp_grant_q.size() != 0 || exp_done_q.size() != 0) begin
      tests_failed++;
      $display("FAIL scoreboard_drain: %0d grants, %0d completions left, want 0 0",
               exp_grant_q.size(), exp_done_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
